// File: rtl/h_bridge_burst.sv
// ----------------------------------------------------------------------------
// h_bridge_burst
//
// Transducer ping-burst generator driving the four gate enables of an
// H-bridge. A burst is N full drive periods, each made of
//     DEAD -> PH_A -> DEAD -> PH_B
// followed by one trailing DEAD, an active-damping interval (both low-side
// switches on), and finally high-Z idle. Dead time is inserted before every
// leg turn-on so that complementary switches on one leg never conduct together.
//
// Parameters
//   CLK_DIV    clk cycles per half drive period (must be > DEAD_TIME)
//   DEAD_TIME  all-off clk cycles inserted before each leg turns on (0 = none)
//   CYCLES_W   width of num_cycles
//   DAMP_W     width of damp_cycles
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        burst request, honoured only while idle
//   abort        terminate the burst at the next edge, no damping, no done
//   num_cycles   drive periods per burst, latched on an accepted start
//   damp_cycles  damping length in clk cycles, latched on an accepted start
//   busy         high from accepted start until the return to idle
//   tx_active    high during drive and dead states (receiver blanking)
//   done         one-cycle pulse on normal completion (first idle cycle)
//   hlh, hll     left leg high / low gate enables
//   hrh, hrl     right leg high / low gate enables
//
// All outputs are registered and change on the same edge as the state
// register: the output decode works on the next state, not the current one.
// ----------------------------------------------------------------------------
module h_bridge_burst #(
    parameter int CLK_DIV   = 32,
    parameter int DEAD_TIME = 2,
    parameter int CYCLES_W  = 8,
    parameter int DAMP_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CYCLES_W-1:0] num_cycles,
    input  logic [DAMP_W-1:0]   damp_cycles,
    output logic                busy,
    output logic                tx_active,
    output logic                done,
    output logic                hlh,
    output logic                hll,
    output logic                hrh,
    output logic                hrl
);

    localparam int TW = $clog2(CLK_DIV + 1);

    // Last timer value of a dead interval / a drive phase. DEAD_LAST is only
    // consulted when DEAD_TIME > 0, so clamp it to keep it well defined.
    localparam logic [TW-1:0] DEAD_LAST = TW'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
    localparam logic [TW-1:0] PH_LAST   = TW'(CLK_DIV - DEAD_TIME - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    // Three distinct dead states so each one knows where it leads; all of them
    // decode to all-gates-off.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEAD_A = 3'd1,
        S_PH_A   = 3'd2,
        S_DEAD_B = 3'd3,
        S_PH_B   = 3'd4,
        S_DEAD_T = 3'd5,
        S_DAMP   = 3'd6
    } state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         timer_reg, timer_next;
    logic [CYCLES_W-1:0]   cyc_reg, cyc_next;
    logic [CYCLES_W-1:0]   n_lat_reg, n_lat_next;
    logic [DAMP_W-1:0]     damp_lat_reg, damp_lat_next;
    logic [DAMP_W-1:0]     damp_cnt_reg, damp_cnt_next;
    logic                  done_next;

    logic                  busy_reg, busy_next;
    logic                  tx_active_reg, tx_active_next;
    logic                  done_reg;
    logic                  hlh_reg, hlh_next;
    logic                  hll_reg, hll_next;
    logic                  hrh_reg, hrh_next;
    logic                  hrl_reg, hrl_next;

    // One extra bit so the completed-period count can never wrap before the
    // comparison against the latched N.
    logic [CYCLES_W:0]     cyc_inc;

    assign cyc_inc = {1'b0, cyc_reg} + {{CYCLES_W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            cyc_reg       <= '0;
            n_lat_reg     <= '0;
            damp_lat_reg  <= '0;
            damp_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            tx_active_reg <= 1'b0;
            done_reg      <= 1'b0;
            hlh_reg       <= 1'b0;
            hll_reg       <= 1'b0;
            hrh_reg       <= 1'b0;
            hrl_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            cyc_reg       <= cyc_next;
            n_lat_reg     <= n_lat_next;
            damp_lat_reg  <= damp_lat_next;
            damp_cnt_reg  <= damp_cnt_next;
            busy_reg      <= busy_next;
            tx_active_reg <= tx_active_next;
            done_reg      <= done_next;
            hlh_reg       <= hlh_next;
            hll_reg       <= hll_next;
            hrh_reg       <= hrh_next;
            hrl_reg       <= hrl_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg + TIMER_ONE;
        cyc_next      = cyc_reg;
        n_lat_next    = n_lat_reg;
        damp_lat_next = damp_lat_reg;
        damp_cnt_next = damp_cnt_reg;
        done_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                timer_next = '0;
                if (start && !abort) begin
                    n_lat_next    = num_cycles;
                    damp_lat_next = damp_cycles;
                    cyc_next      = '0;
                    damp_cnt_next = '0;
                    if (num_cycles != '0) begin
                        state_next = (DEAD_TIME > 0) ? S_DEAD_A : S_PH_A;
                    end else if (damp_cycles != '0) begin
                        // No drive requested: damping only, no dead interval.
                        state_next = S_DAMP;
                    end else begin
                        // Empty burst: stay idle, report completion at once.
                        done_next = 1'b1;
                    end
                end
            end

            S_DEAD_A: begin
                if (timer_reg == DEAD_LAST) begin
                    state_next = S_PH_A;
                    timer_next = '0;
                end
            end

            S_PH_A: begin
                if (timer_reg == PH_LAST) begin
                    state_next = (DEAD_TIME > 0) ? S_DEAD_B : S_PH_B;
                    timer_next = '0;
                end
            end

            S_DEAD_B: begin
                if (timer_reg == DEAD_LAST) begin
                    state_next = S_PH_B;
                    timer_next = '0;
                end
            end

            S_PH_B: begin
                if (timer_reg == PH_LAST) begin
                    timer_next = '0;
                    cyc_next   = cyc_inc[CYCLES_W-1:0];
                    if (cyc_inc == {1'b0, n_lat_reg}) begin
                        // Last drive period finished.
                        if (DEAD_TIME > 0) begin
                            state_next = S_DEAD_T;
                        end else if (damp_lat_reg != '0) begin
                            state_next = S_DAMP;
                        end else begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        state_next = (DEAD_TIME > 0) ? S_DEAD_A : S_PH_A;
                    end
                end
            end

            S_DEAD_T: begin
                if (timer_reg == DEAD_LAST) begin
                    timer_next = '0;
                    if (damp_lat_reg != '0) begin
                        state_next = S_DAMP;
                    end else begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            S_DAMP: begin
                timer_next    = '0;
                damp_cnt_next = damp_cnt_reg + DAMP_W'(1);
                if (damp_cnt_reg == damp_lat_reg - DAMP_W'(1)) begin
                    state_next    = S_IDLE;
                    damp_cnt_next = '0;
                    done_next     = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase

        // Abort overrides everything, including a completion in the same cycle.
        if (abort && (state_reg != S_IDLE)) begin
            state_next    = S_IDLE;
            timer_next    = '0;
            damp_cnt_next = '0;
            done_next     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (from the next state, so it registers alongside it)
    // ------------------------------------------------------------------
    always_comb begin
        busy_next      = 1'b0;
        tx_active_next = 1'b0;
        hlh_next       = 1'b0;
        hll_next       = 1'b0;
        hrh_next       = 1'b0;
        hrl_next       = 1'b0;

        case (state_next)
            S_DEAD_A, S_DEAD_B, S_DEAD_T: begin
                busy_next      = 1'b1;
                tx_active_next = 1'b1;
            end
            S_PH_A: begin
                busy_next      = 1'b1;
                tx_active_next = 1'b1;
                hlh_next       = 1'b1;
                hrl_next       = 1'b1;
            end
            S_PH_B: begin
                busy_next      = 1'b1;
                tx_active_next = 1'b1;
                hll_next       = 1'b1;
                hrh_next       = 1'b1;
            end
            S_DAMP: begin
                // Both low sides on: shorts the transducer to damp ringing.
                busy_next      = 1'b1;
                hll_next       = 1'b1;
                hrl_next       = 1'b1;
            end
            default: begin
                busy_next      = 1'b0;
            end
        endcase
    end

    assign busy      = busy_reg;
    assign tx_active = tx_active_reg;
    assign done      = done_reg;
    assign hlh       = hlh_reg;
    assign hll       = hll_reg;
    assign hrh       = hrh_reg;
    assign hrl       = hrl_reg;

endmodule

// File: tb/tb_h_bridge_burst.sv
// ----------------------------------------------------------------------------
// tb_h_bridge_burst
//
// Two instances: dut0 with default timing (CLK_DIV=32, DEAD_TIME=2) and dut1
// with CLK_DIV=4, DEAD_TIME=0. For every launched burst the expected output
// vector of each cycle is derived from the burst timing formula and queued;
// every cycle one entry per instance is popped (all-zero when its queue is
// empty) and compared, together with the shoot-through invariant.
// Vector layout: {busy, tx_active, done, hlh, hll, hrh, hrl}.
// ----------------------------------------------------------------------------
module tb_h_bridge_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, abort0, start1, abort1;
    logic [7:0]  num0, num1;
    logic [15:0] damp0, damp1;

    logic busy0, tx0, done0, hlh0, hll0, hrh0, hrl0;
    logic busy1, tx1, done1, hlh1, hll1, hrh1, hrl1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [6:0] q0[$];
    logic [6:0] q1[$];

    always #5 clk = ~clk;

    h_bridge_burst dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .num_cycles(num0), .damp_cycles(damp0),
        .busy(busy0), .tx_active(tx0), .done(done0),
        .hlh(hlh0), .hll(hll0), .hrh(hrh0), .hrl(hrl0)
    );

    h_bridge_burst #(.CLK_DIV(4), .DEAD_TIME(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .num_cycles(num1), .damp_cycles(damp1),
        .busy(busy1), .tx_active(tx1), .done(done1),
        .hlh(hlh1), .hll(hll1), .hrh(hrh1), .hrl(hrl1)
    );

    // Expected vector k cycles after the accepted start edge.
    function automatic logic [6:0] exp_at(input int k, input int n, input int dm,
                                          input int c, input int d);
        int drv;
        int p;
        drv = (n > 0) ? 2 * n * c + d : 0;
        if (k < drv) begin
            if (k < 2 * n * c) begin
                p = k % (2 * c);
                if (p < d)          return 7'b1100000;
                else if (p < c)     return 7'b1101001;
                else if (p < c + d) return 7'b1100000;
                else                return 7'b1100110;
            end
            return 7'b1100000;
        end
        if (k < drv + dm)  return 7'b1000101;
        if (k == drv + dm) return 7'b0010000;
        return 7'b0000000;
    endfunction

    task automatic launch0(input int n, input int dm);
        int tot;
        tot    = ((n > 0) ? 2 * n * 32 + 2 : 0) + dm;
        num0   = 8'(n);
        damp0  = 16'(dm);
        start0 = 1'b1;
        for (int k = 0; k <= tot; k++) q0.push_back(exp_at(k, n, dm, 32, 2));
        $display("burst dut0 N=%0d damp=%0d busy_len=%0d", n, dm, tot);
    endtask

    task automatic launch1(input int n, input int dm);
        int tot;
        tot    = ((n > 0) ? 2 * n * 4 : 0) + dm;
        num1   = 8'(n);
        damp1  = 16'(dm);
        start1 = 1'b1;
        for (int k = 0; k <= tot; k++) q1.push_back(exp_at(k, n, dm, 4, 0));
        $display("burst dut1 N=%0d damp=%0d busy_len=%0d", n, dm, tot);
    endtask

    task automatic check_cycle();
        logic [6:0] e0, e1, o0, o1;
        @(negedge clk);
        cyc++;
        e0 = 7'b0;
        e1 = 7'b0;
        if (q0.size() > 0) e0 = q0.pop_front();
        if (q1.size() > 0) e1 = q1.pop_front();
        o0 = {busy0, tx0, done0, hlh0, hll0, hrh0, hrl0};
        o1 = {busy1, tx1, done1, hlh1, hll1, hrh1, hrl1};
        checks++;
        assert (o0 === e0) else begin
            errors++;
            $error("FAIL dut0_vec cyc=%0d observed=%b expected=%b", cyc, o0, e0);
        end
        checks++;
        assert (o1 === e1) else begin
            errors++;
            $error("FAIL dut1_vec cyc=%0d observed=%b expected=%b", cyc, o1, e1);
        end
        checks++;
        assert (((hlh0 & hll0) | (hrh0 & hrl0) | (hlh1 & hll1) | (hrh1 & hrl1)) === 1'b0) else begin
            errors++;
            $error("FAIL shoot_through cyc=%0d observed=%b%b%b%b/%b%b%b%b expected=no_leg_short",
                   cyc, hlh0, hll0, hrh0, hrl0, hlh1, hll1, hrh1, hrl1);
        end
    endtask

    task automatic drain();
        while ((q0.size() > 0) || (q1.size() > 0)) check_cycle();
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; num0 = '0; damp0 = '0;
        start1 = 1'b0; abort1 = 1'b0; num1 = '0; damp1 = '0;

        // Reset state
        repeat (3) check_cycle();
        rst = 1'b0;
        check_cycle();

        // Default burst N=4 damp=100
        launch0(4, 100);
        check_cycle();
        start0 = 1'b0;
        drain();
        repeat (2) check_cycle();

        // Damping only, then an empty burst
        launch0(0, 10);
        check_cycle();
        start0 = 1'b0;
        drain();
        check_cycle();
        launch0(0, 0);
        check_cycle();
        start0 = 1'b0;
        drain();
        repeat (2) check_cycle();

        // abort and start together while idle: abort wins
        start0 = 1'b1;
        abort0 = 1'b1;
        num0   = 8'd2;
        damp0  = 16'd5;
        $display("idle abort+start dut0");
        check_cycle();
        start0 = 1'b0;
        abort0 = 1'b0;
        check_cycle();

        // Abort at cycle 50 of an N=8 burst, restart straight after
        launch0(8, 100);
        for (int k = 0; k <= 50; k++) begin
            check_cycle();
            start0 = 1'b0;
        end
        q0.delete();
        abort0 = 1'b1;
        start0 = 1'b1;
        $display("abort dut0 at cycle 50");
        check_cycle();
        abort0 = 1'b0;
        launch0(1, 0);
        check_cycle();
        start0 = 1'b0;
        drain();
        check_cycle();

        // start held high, num_cycles changed mid-burst: latched N=3 rules
        launch0(3, 20);
        for (int k = 0; q0.size() > 0; k++) begin
            check_cycle();
            if (k == 10)  num0 = 8'd1;
            if (k == 200) start0 = 1'b0;
        end
        repeat (5) check_cycle();

        // Reset in the middle of damping
        launch0(2, 50);
        for (int k = 0; k <= 140; k++) begin
            check_cycle();
            start0 = 1'b0;
        end
        q0.delete();
        rst = 1'b1;
        $display("reset dut0 mid-damp");
        check_cycle();
        rst = 1'b0;
        repeat (3) check_cycle();

        // No dead time, short period
        launch1(2, 0);
        check_cycle();
        start1 = 1'b0;
        drain();
        repeat (2) check_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
